// File: rtl/stopwatch_pkg.sv
// Shared types and prescaler sizing helpers for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    LAP   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } sw_state_t;

  function automatic int sw_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Width holds 0..DIV-1; never below one bit.
  function automatic int sw_presc_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button/flag inputs and counter/display controls of the stopwatch controller.
interface stopwatch_ctrl_if;
  logic btn_ss;
  logic btn_lap;
  logic mode_down;
  logic count_max;
  logic count_zero;
  logic cnt_en;
  logic cnt_up;
  logic cnt_clr;
  logic disp_freeze;
  logic running;
  logic done;

  modport master (
    input  btn_ss, btn_lap, mode_down, count_max, count_zero,
    output cnt_en, cnt_up, cnt_clr, disp_freeze, running, done
  );

  modport slave (
    output btn_ss, btn_lap, mode_down, count_max, count_zero,
    input  cnt_en, cnt_up, cnt_clr, disp_freeze, running, done
  );
endinterface

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Rising-edge detector; history resets high so a level held through reset
// is not seen as a press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic press
);
  logic prev_q, prev_d;

  always_comb begin
    prev_d = level;
  end

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= prev_d;
  end

  assign press = level & ~prev_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer with tick prescaler for the stopwatch counter.
// Optional countdown mode enabled by defining STOPWATCH_COUNTDOWN_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input logic clk,
  input logic rst,
  stopwatch_ctrl_if.master sw
);
  localparam int DIV = sw_div(CLK_HZ, TICK_HZ);
  localparam int PW  = sw_presc_w(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  sw_state_t      state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           cnt_en_q, cnt_en_d;
  logic           cnt_up_q, cnt_up_d;
  logic           cnt_clr_q, cnt_clr_d;
  logic           freeze_q, freeze_d;
  logic           running_q, running_d;
  logic           done_q, done_d;

  logic ss_press, lap_press_raw, lap_press;
  logic counting, tick, term_flag, start_block, start_up;

  btn_edge u_ss_edge (
    .clk   (clk),
    .rst   (rst),
    .level (sw.btn_ss),
    .press (ss_press)
  );

  btn_edge u_lap_edge (
    .clk   (clk),
    .rst   (rst),
    .level (sw.btn_lap),
    .press (lap_press_raw)
  );

  // Start/stop has priority when both buttons rise together.
  assign lap_press = lap_press_raw & ~ss_press;

`ifdef STOPWATCH_COUNTDOWN_EN
  assign term_flag   = cnt_up_q ? sw.count_max : sw.count_zero;
  assign start_block = sw.mode_down & sw.count_zero;
  assign start_up    = ~sw.mode_down;
`else
  logic unused_inputs;
  assign unused_inputs = &{1'b0, sw.mode_down, sw.count_zero};
  assign term_flag   = sw.count_max;
  assign start_block = 1'b0;
  assign start_up    = 1'b1;
`endif

  assign counting = (state_q == RUN) || (state_q == LAP);
  assign tick     = counting && (presc_q == PRESC_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_clr_d = 1'b0;
    cnt_up_d  = cnt_up_q;

    case (state_q)
      IDLE: begin
        if (ss_press && !start_block) begin
          state_d  = RUN;
          cnt_up_d = start_up;
        end else if (lap_press) begin
          cnt_clr_d = 1'b1;
        end
      end
      RUN: begin
        if (ss_press)               state_d = PAUSE;
        else if (lap_press)         state_d = LAP;
        else if (tick && term_flag) state_d = DONE;
      end
      LAP: begin
        if (ss_press)               state_d = PAUSE;
        else if (lap_press)         state_d = RUN;
        else if (tick && term_flag) state_d = DONE;
      end
      PAUSE: begin
        if (ss_press) begin
          state_d = RUN;
        end else if (lap_press) begin
          state_d   = IDLE;
          cnt_clr_d = 1'b1;
        end
      end
      DONE: begin
        if (lap_press) begin
          state_d   = IDLE;
          cnt_clr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) cnt_up_d = 1'b1;

    // PAUSE keeps the fractional tick so resuming does not lose time.
    case (state_q)
      RUN, LAP: presc_d = tick ? '0 : presc_q + PW'(1);
      PAUSE:    presc_d = presc_q;
      default:  presc_d = '0;
    endcase

    cnt_en_d  = tick && !term_flag;
    running_d = (state_d == RUN) || (state_d == LAP);
    freeze_d  = (state_d == LAP);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      cnt_en_q  <= 1'b0;
      cnt_up_q  <= 1'b1;
      cnt_clr_q <= 1'b0;
      freeze_q  <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_en_q  <= cnt_en_d;
      cnt_up_q  <= cnt_up_d;
      cnt_clr_q <= cnt_clr_d;
      freeze_q  <= freeze_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign sw.cnt_en      = cnt_en_q;
  assign sw.cnt_up      = cnt_up_q;
  assign sw.cnt_clr     = cnt_clr_q;
  assign sw.disp_freeze = freeze_q;
  assign sw.running     = running_q;
  assign sw.done        = done_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a cycle-level reference model.
module tb_stopwatch_ctrl;
  localparam int DIV = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 run, 2 lap, 3 pause, 4 done.
  int m_mode = 0;
  int m_phase = 0;
  bit m_ss_prev = 1'b1, m_lap_prev = 1'b1;
  bit m_en = 1'b0, m_clr = 1'b0, m_up = 1'b1;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    bit ss_p, lap_p, tk, term, going_idle;
    int nmode;
    if (rst) begin
      m_mode <= 0; m_phase <= 0; m_en <= 1'b0; m_clr <= 1'b0; m_up <= 1'b1;
      m_ss_prev <= 1'b1; m_lap_prev <= 1'b1; m_valid <= 1'b1;
    end else begin
      ss_p  = sw_if.btn_ss && !m_ss_prev;
      lap_p = sw_if.btn_lap && !m_lap_prev && !ss_p;
      tk    = (m_mode == 1 || m_mode == 2) && (m_phase == DIV - 1);
`ifdef STOPWATCH_COUNTDOWN_EN
      term  = m_up ? sw_if.count_max : sw_if.count_zero;
`else
      term  = sw_if.count_max;
`endif
      nmode = m_mode;
      going_idle = 1'b0;
      if (m_mode == 0) begin
        if (ss_p) begin
`ifdef STOPWATCH_COUNTDOWN_EN
          if (!(sw_if.mode_down && sw_if.count_zero)) begin
            nmode = 1;
            m_up <= !sw_if.mode_down;
          end
`else
          nmode = 1;
`endif
        end else if (lap_p) going_idle = 1'b1;
      end else if (m_mode == 1 || m_mode == 2) begin
        if (ss_p) nmode = 3;
        else if (lap_p) nmode = (m_mode == 1) ? 2 : 1;
        else if (tk && term) nmode = 4;
      end else if (m_mode == 3) begin
        if (ss_p) nmode = 1;
        else if (lap_p) begin nmode = 0; going_idle = 1'b1; end
      end else begin
        if (lap_p) begin nmode = 0; going_idle = 1'b1; end
      end
      if (nmode == 0) m_up <= 1'b1;
      m_clr  <= going_idle;
      m_en   <= tk && !term;
      m_phase <= (m_mode == 1 || m_mode == 2) ? (m_phase + 1) % DIV :
                 (m_mode == 3) ? m_phase : 0;
      m_mode <= nmode;
      m_ss_prev  <= sw_if.btn_ss;
      m_lap_prev <= sw_if.btn_lap;
    end
  end

  always @(negedge clk) begin
    logic [5:0] act, exp;
    if (m_valid) begin
      act = {sw_if.cnt_en, sw_if.cnt_up, sw_if.cnt_clr, sw_if.disp_freeze,
             sw_if.running, sw_if.done};
      exp = {m_en, m_up, m_clr, (m_mode == 2), (m_mode == 1 || m_mode == 2),
             (m_mode == 4)};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got en/up/clr/frz/run/done=%b expected %b",
                 $time, act, exp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_ss();
    sw_if.btn_ss = 1'b1; step(); sw_if.btn_ss = 1'b0;
  endtask

  task automatic press_lap();
    sw_if.btn_lap = 1'b1; step(); sw_if.btn_lap = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(3); rst = 1'b0; step();
  endtask

  initial begin
    int cnt, first;
    sw_if.btn_ss = 1'b0; sw_if.btn_lap = 1'b0; sw_if.mode_down = 1'b0;
    sw_if.count_max = 1'b0; sw_if.count_zero = 1'b0;
    do_reset();
    chk("reset_running", sw_if.running, 0);
    chk("reset_cnt_up", sw_if.cnt_up, 1);
    chk("reset_done", sw_if.done, 0);

    // Start and count
    press_ss();
    chk("start_running", sw_if.running, 1);
    cnt = 0; first = 0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (sw_if.cnt_en) begin cnt++; if (first == 0) first = k; end
    end
    chk("start_first_en", first, 10);
    chk("start_en_count", cnt, 5);

    // Pause with prescaler held at 4, then resume
    step(3);
    press_ss();
    chk("pause_running", sw_if.running, 0);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin step(); if (sw_if.cnt_en) cnt++; end
    chk("pause_no_en", cnt, 0);
    press_ss();
    chk("resume_running", sw_if.running, 1);
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (sw_if.cnt_en && first == 0) first = k;
    end
    chk("resume_first_en", first, 6);

    // Lap freeze keeps counting
    press_lap();
    chk("lap_freeze", sw_if.disp_freeze, 1);
    chk("lap_running", sw_if.running, 1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin step(); if (sw_if.cnt_en) cnt++; end
    chk("lap_en_count", cnt, 1);
    press_lap();
    chk("unlap_freeze", sw_if.disp_freeze, 0);
    chk("unlap_running", sw_if.running, 1);

    // Terminal saturation
    sw_if.count_max = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12 && !sw_if.done; k++) begin
      step(); if (sw_if.cnt_en) cnt++;
    end
    chk("term_done", sw_if.done, 1);
    chk("term_no_en", cnt, 0);
    step(2);
    press_ss();
    step();
    chk("done_ignores_ss", sw_if.done, 1);
    chk("done_not_running", sw_if.running, 0);
    sw_if.count_max = 1'b0;
    press_lap();
    chk("done_clr", sw_if.cnt_clr, 1);
    chk("done_to_idle", sw_if.done, 0);
    step();
    chk("clr_one_cycle", sw_if.cnt_clr, 0);
    step();
    press_lap();
    chk("idle_lap_clr", sw_if.cnt_clr, 1);
    chk("idle_lap_running", sw_if.running, 0);
    step();

    // Same-cycle presses
    press_ss();
    step(3);
    sw_if.btn_ss = 1'b1; sw_if.btn_lap = 1'b1; step();
    sw_if.btn_ss = 1'b0; sw_if.btn_lap = 1'b0;
    chk("both_running", sw_if.running, 0);
    chk("both_freeze", sw_if.disp_freeze, 0);
    step();
    press_ss();
    chk("resume2_running", sw_if.running, 1);
    step(4);

    // Reset with start/stop held
    sw_if.btn_ss = 1'b1; rst = 1'b1; step(2); rst = 1'b0; step(3);
    chk("rst_held_running", sw_if.running, 0);
    chk("rst_no_clr", sw_if.cnt_clr, 0);
    sw_if.btn_ss = 1'b0; step();
    press_ss();
    chk("rst_repress_running", sw_if.running, 1);
    step(5);

`ifdef STOPWATCH_COUNTDOWN_EN
    do_reset();
    sw_if.mode_down = 1'b1; sw_if.count_zero = 1'b1;
    press_ss();
    chk("cd_block_at_zero", sw_if.running, 0);
    step();
    sw_if.count_zero = 1'b0;
    press_ss();
    chk("cd_running", sw_if.running, 1);
    chk("cd_cnt_up", sw_if.cnt_up, 0);
    sw_if.mode_down = 1'b0;
    step(3);
    sw_if.count_zero = 1'b1;
    for (int k = 0; k < 12 && !sw_if.done; k++) step();
    chk("cd_done", sw_if.done, 1);
    press_lap();
    chk("cd_idle_up", sw_if.cnt_up, 1);
    sw_if.count_zero = 1'b0;
    step(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
